// File: rtl/jpeg_block_scheduler_pkg.sv
// Shared types and block geometry for the JPEG block scheduler and its output buffer.
package jpeg_pkg;

    localparam int PIX_W      = 8;
    localparam int COEF_W     = 10;
    localparam int NPIX       = 64;
    localparam int BLK_RGB_W  = NPIX * PIX_W;
    localparam int BLK_COEF_W = NPIX * COEF_W;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } sched_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/jpeg_block_scheduler_obuf.sv
// jsched_obuf: synchronous first-word-fall-through FIFO holding datapath results.
module jsched_obuf #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + PTR_ONE;
            if (pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wptr] <= push_data;
    end

    always_comb begin
        empty = (r_count == '0);
        head  = r_mem[r_rptr];
    end

endmodule

// File: rtl/jpeg_block_scheduler.sv
// Issues RGB blocks into a fixed-latency, non-stallable datapath and buffers tagged results.
// Optional JPEG_SCHED_PERF_EN adds perf_stall / perf_blocks saturating counters.
module jpeg_block_scheduler
    import jpeg_pkg::*;
#(
    parameter int LAT        = 12,
    parameter int OBUF_DEPTH = 4,
    parameter int ID_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BLK_RGB_W-1:0]  in_R,
    input  logic [BLK_RGB_W-1:0]  in_G,
    input  logic [BLK_RGB_W-1:0]  in_B,
    input  logic                  flush,
    output logic [BLK_RGB_W-1:0]  dp_R,
    output logic [BLK_RGB_W-1:0]  dp_G,
    output logic [BLK_RGB_W-1:0]  dp_B,
    input  logic [BLK_COEF_W-1:0] dp_Y,
    input  logic [BLK_COEF_W-1:0] dp_Cb,
    input  logic [BLK_COEF_W-1:0] dp_Cr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BLK_COEF_W-1:0] out_Y,
    output logic [BLK_COEF_W-1:0] out_Cb,
    output logic [BLK_COEF_W-1:0] out_Cr,
    output logic [ID_W-1:0]       out_id,
    output logic                  flush_done,
    output logic                  busy
`ifdef JPEG_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_stall,
    output logic [31:0]           perf_blocks
`endif
);

    localparam int CW = $clog2(OBUF_DEPTH + 1);
    localparam int FW = 3 * BLK_COEF_W + ID_W;
    localparam logic [CW-1:0]   CRED_MAX = CW'(OBUF_DEPTH);
    localparam logic [CW-1:0]   CRED_ONE = 1;
    localparam logic [ID_W-1:0] ID_ONE   = 1;

    sched_state_t    r_state;
    logic [CW-1:0]   r_credits;
    logic [CW-1:0]   w_credits_nxt;
    logic [ID_W-1:0] r_id;
    logic [LAT-1:0]  r_vld_pipe;
    logic [ID_W-1:0] r_tag_pipe [LAT];
    logic            w_accept;
    logic            w_pop;
    logic            w_push;
    logic            w_empty;
    logic [FW-1:0]   w_head;

    always_comb begin
        in_ready  = (r_state == ST_RUN) && (r_credits != '0) && reset;
        w_accept  = in_valid && in_ready;
        out_valid = !w_empty;
        w_pop     = out_valid && out_ready;
        w_push    = r_vld_pipe[LAT-1];
        busy      = (r_credits != CRED_MAX);
        // A credit is held from accept until the result leaves the FIFO.
        w_credits_nxt = r_credits;
        if (w_accept && !w_pop)
            w_credits_nxt = r_credits - CRED_ONE;
        else if (!w_accept && w_pop)
            w_credits_nxt = r_credits + CRED_ONE;
        {out_Y, out_Cb, out_Cr, out_id} = w_empty ? '0 : w_head;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_credits  <= CRED_MAX;
            r_id       <= '0;
            r_vld_pipe <= '0;
            dp_R       <= '0;
            dp_G       <= '0;
            dp_B       <= '0;
        end else begin
            r_credits     <= w_credits_nxt;
            r_vld_pipe[0] <= w_accept;
            for (int i = 1; i < LAT; i++)
                r_vld_pipe[i] <= r_vld_pipe[i-1];
            if (w_accept) begin
                r_id <= r_id + ID_ONE;
                dp_R <= in_R;
                dp_G <= in_G;
                dp_B <= in_B;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_tag_pipe[0] <= r_id;
        for (int i = 1; i < LAT; i++)
            r_tag_pipe[i] <= r_tag_pipe[i-1];
    end

    // Drain completes on the edge the last outstanding credit returns.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (flush) r_state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (w_credits_nxt == CRED_MAX) begin
                        flush_done <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    jsched_obuf #(
        .DEPTH  (OBUF_DEPTH),
        .DATA_W (FW)
    ) u_obuf (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data ({dp_Y, dp_Cb, dp_Cr, r_tag_pipe[LAT-1]}),
        .pop       (w_pop),
        .empty     (w_empty),
        .head      (w_head)
    );

`ifdef JPEG_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall  <= '0;
            perf_blocks <= '0;
        end else begin
            if (in_valid && !in_ready) perf_stall  <= sat_inc32(perf_stall);
            if (w_pop)                 perf_blocks <= sat_inc32(perf_blocks);
        end
    end
`endif

endmodule
